// File: rtl/instr_fetch_unit_pkg.sv
// Shared processor package: opcode constants plus fetch FSM encoding.
// Fetch unit imports its state type and reset PC default from here.
package instr_fetch_unit_pkg;

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h01;
  localparam logic [5:0] OP_LD   = 6'h02;
  localparam logic [5:0] OP_ST   = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_JMP  = 6'h05;
  localparam logic [5:0] OP_JR   = 6'h06;
  localparam logic [5:0] OP_HALT = 6'h3F;

  localparam logic [31:0] PC_RESET_DEF = 32'd0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_DELIVER = 2'd2,
    S_HALT    = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch FSM: requests imem at pc, holds instr until
// the branch mux supplies a final next-PC or decode flags halt.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(PC_RESET_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] npc,
  input  logic              npc_valid,
  input  logic              halt,
  output logic              halted,
  output logic [31:0]       fetch_count
);

  fetch_state_e      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_instr;
  logic [31:0]       r_fetch_count;
  logic              r_imem_req;
  logic              r_instr_valid;
  logic              r_halted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_instr       <= 32'd0;
      r_fetch_count <= 32'd0;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (en) begin
            r_state    <= S_REQ;
            r_imem_req <= 1'b1;
          end
        end
        // en is ignored here: an issued request always completes
        S_REQ: begin
          if (imem_ack) begin
            r_instr       <= imem_rdata;
            r_fetch_count <= r_fetch_count + 32'd1;
            r_state       <= S_DELIVER;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b1;
          end
        end
        S_DELIVER: begin
          if (halt) begin
            r_state       <= S_HALT;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b1;
          end else if (npc_valid) begin
            r_pc          <= npc;
            r_instr_valid <= 1'b0;
            r_state       <= en ? S_REQ : S_IDLE;
            r_imem_req    <= en;
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign halted      = r_halted;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a scoreboard of
// expected fetch results popped when instr_valid appears.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  typedef struct {
    logic [31:0] word;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        npc_valid;
  logic        halt;
  logic        halted;
  logic [31:0] fetch_count;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  logic [31:0] cnt_model;

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'd0)) dut (
    .clk(clk), .rst(rst), .en(en),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .pc(pc),
    .npc(npc), .npc_valid(npc_valid), .halt(halt),
    .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag);
    int k;
    k = 0;
    while (imem_req !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk({tag, "_req_seen"}, {31'd0, imem_req}, 32'd1);
  endtask

  // waits for the request, acks after `waits` idle cycles, then
  // compares the delivered instruction against the scoreboard
  task automatic do_fetch(input string tag, input int waits,
                          input logic [31:0] data,
                          input logic [31:0] addr);
    exp_t e;
    wait_req(tag);
    chk({tag, "_addr"}, imem_addr, addr);
    for (int i = 0; i < waits; i++) begin
      tick();
      chk({tag, "_req_held"}, {31'd0, imem_req}, 32'd1);
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    cnt_model  = cnt_model + 32'd1;
    sb.push_back('{word: data, cnt: cnt_model});
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, "_req_off"}, {31'd0, imem_req}, 32'd0);
    if (instr_valid === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_instr"}, instr, e.word);
      chk({tag, "_count"}, fetch_count, e.cnt);
    end
  endtask

  initial begin
    int reqs;
    rst = 1'b1; en = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
    npc = 32'h0; npc_valid = 1'b0; halt = 1'b0;
    cnt_model = 32'd0;
    tick(); tick();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_count", fetch_count, 32'd0);

    rst = 1'b0;
    tick();
    do_fetch("f1", 2, 32'h12345678, 32'h0);

    tick();
    chk("hold_valid", {31'd0, instr_valid}, 32'd1);
    chk("hold_instr", instr, 32'h12345678);
    chk("hold_pc", pc, 32'h0);

    npc = 32'h40; npc_valid = 1'b1;
    tick();
    npc_valid = 1'b0;
    chk("npc_pc", pc, 32'h40);
    chk("npc_valid_drop", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("npc_req", {31'd0, imem_req}, 32'd1);
    chk("npc_addr", imem_addr, 32'h40);

    en = 1'b0;
    do_fetch("f2", 3, 32'hA5A50001, 32'h40);
    npc = 32'h80; npc_valid = 1'b1;
    tick();
    npc_valid = 1'b0;
    chk("idle_pc", pc, 32'h80);
    reqs = 0;
    npc = 32'h123; npc_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (imem_req === 1'b1) reqs++;
    end
    npc_valid = 1'b0;
    chk("idle_no_req", reqs, 32'd0);
    chk("idle_npc_ignored", pc, 32'h80);

    en = 1'b1;
    tick();
    do_fetch("f3", 0, 32'hDEADBEEF, 32'h80);
    halt = 1'b1; npc = 32'h99; npc_valid = 1'b1;
    tick();
    halt = 1'b0; npc_valid = 1'b0;
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_pc", pc, 32'h80);
    reqs = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (imem_req === 1'b1) reqs++;
    end
    chk("halt_no_req", reqs, 32'd0);
    chk("halt_stays", {31'd0, halted}, 32'd1);
    chk("halt_pc_20", pc, 32'h80);

    rst = 1'b1;
    #1;
    chk("rst_async_halted", {31'd0, halted}, 32'd0);
    chk("rst_async_pc", pc, 32'h0);
    cnt_model = 32'd0;
    tick();
    rst = 1'b0;
    wait_req("f4");
    imem_ack = 1'b1; imem_rdata = 32'hCAFEF00D;
    rst = 1'b1;
    #1;
    chk("rst_req_async", {31'd0, imem_req}, 32'd0);
    tick();
    imem_ack = 1'b0;
    en = 1'b0;
    rst = 1'b0;
    tick();
    chk("rst_ack_instr", instr, 32'h0);
    chk("rst_ack_count", fetch_count, 32'h0);
    chk("rst_ack_pc", pc, 32'h0);
    chk("rst_ack_valid", {31'd0, instr_valid}, 32'd0);

    force dut.r_fetch_count = 32'hFFFFFFFF;
    tick();
    release dut.r_fetch_count;
    tick();
    cnt_model = 32'hFFFFFFFF;
    en = 1'b1;
    tick();
    do_fetch("wrap", 1, 32'h0BADF00D, 32'h0);
    chk("wrap_zero", fetch_count, 32'h0);

    chk("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
